// File: rtl/rtc_pkg.sv
// rtc_pkg: shared widths, range limits and set-handshake state type for the
// time-of-day counter.
package rtc_pkg;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

  // IDLE: ready to accept a set request; ACK: one-cycle back-off after a request.
  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } set_state_t;

endpackage

// File: rtl/rtc_mod_counter.sv
// rtc_mod_counter: modulo-(MAX+1) counter used for both prescalers and the
// sec/min/hour/day cascade.
// Ports:
//   clk, x_clr   clock, synchronous active-low clear
//   inc          advance by one this cycle
//   load         load load_val (wins over inc and suppresses carry)
//   load_val     value to load
//   count        current count 0..MAX
//   carry        combinational: this edge wraps MAX -> 0
module rtc_mod_counter #(
  parameter int W   = 6,
  parameter int MAX = 59
) (
  input  logic         clk,
  input  logic         x_clr,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         carry
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  assign carry = inc & ~load & (count == MAX_V);

  always_ff @(posedge clk) begin
    if (!x_clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= carry ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/rtc_time_counter.sv
// rtc_time_counter: prescaled time-of-day counter (seconds, minutes, hours,
// days) with a validated time-set handshake and run/stop control.
// Ports:
//   clk, x_clr            clock, synchronous active-low reset
//   run                   1 = time advances, 0 = hold
//   set_valid/set_ready   time-set handshake; set_err pulses on out-of-range set
//   set_sec/min/hour/day  time to load
//   tick_sub, tick_1s     one-cycle prescaler enables
//   tick_1m/1h/1d         one-cycle rollover enables
//   day_wrap              one-cycle pulse when the day counter wraps
//   sec/min/hour/day_count current time
// Optional build macro RTC_ALARM_EN adds alarm_en, alarm_set, alarm_sec,
// alarm_min, alarm_hour inputs and the alarm_hit output.
module rtc_time_counter
  import rtc_pkg::*;
#(
  parameter int CLK_DIV  = 50000000,
  parameter int SUB_DIV  = 50000,
  parameter int HOUR_MAX = 24,
  parameter int DAY_W    = 10
) (
  input  logic              clk,
  input  logic              x_clr,
  input  logic              run,
  input  logic              set_valid,
  output logic              set_ready,
  input  logic [SEC_W-1:0]  set_sec,
  input  logic [MIN_W-1:0]  set_min,
  input  logic [HOUR_W-1:0] set_hour,
  input  logic [DAY_W-1:0]  set_day,
  output logic              set_err,
  output logic              tick_sub,
  output logic              tick_1s,
  output logic              tick_1m,
  output logic              tick_1h,
  output logic              tick_1d,
  output logic              day_wrap,
  output logic [SEC_W-1:0]  sec_count,
  output logic [MIN_W-1:0]  min_count,
  output logic [HOUR_W-1:0] hour_count,
  output logic [DAY_W-1:0]  day_count
`ifdef RTC_ALARM_EN
  ,
  input  logic              alarm_en,
  input  logic              alarm_set,
  input  logic [SEC_W-1:0]  alarm_sec,
  input  logic [MIN_W-1:0]  alarm_min,
  input  logic [HOUR_W-1:0] alarm_hour,
  output logic              alarm_hit
`endif
);

  localparam int SUB_W = $clog2(SUB_DIV + 1);
  localparam int DIV_W = $clog2(CLK_DIV + 1);

  set_state_t state;
  logic       accept, in_range, load;
  logic       sub_carry, div_carry, sec_carry, min_carry, hour_carry, day_carry;
  logic [SUB_W-1:0] unused_sub_cnt;
  logic [DIV_W-1:0] unused_div_cnt;

  assign in_range = (set_sec <= SEC_MAX) && (set_min <= MIN_MAX) &&
                    (int'(set_hour) < HOUR_MAX);
  assign accept   = set_valid & set_ready;
  // An accepted load suppresses every carry in the cascade, so a set that
  // lands on a tick edge issues no tick pulses.
  assign load     = accept & in_range;

  always_ff @(posedge clk) begin
    if (!x_clr) begin
      state     <= IDLE;
      set_ready <= 1'b0;
      set_err   <= 1'b0;
    end else begin
      set_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= ACK;
            set_ready <= 1'b0;
            set_err   <= ~in_range;
          end else begin
            set_ready <= 1'b1;
          end
        end
        ACK: begin
          state     <= IDLE;
          set_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          set_ready <= 1'b0;
        end
      endcase
    end
  end

  rtc_mod_counter #(.W(SUB_W), .MAX(SUB_DIV - 1)) u_sub_pre (
    .clk(clk), .x_clr(x_clr), .inc(run), .load(load), .load_val('0),
    .count(unused_sub_cnt), .carry(sub_carry)
  );

  rtc_mod_counter #(.W(DIV_W), .MAX(CLK_DIV - 1)) u_sec_pre (
    .clk(clk), .x_clr(x_clr), .inc(run), .load(load), .load_val('0),
    .count(unused_div_cnt), .carry(div_carry)
  );

  rtc_mod_counter #(.W(SEC_W), .MAX(int'(SEC_MAX))) u_sec (
    .clk(clk), .x_clr(x_clr), .inc(div_carry), .load(load), .load_val(set_sec),
    .count(sec_count), .carry(sec_carry)
  );

  rtc_mod_counter #(.W(MIN_W), .MAX(int'(MIN_MAX))) u_min (
    .clk(clk), .x_clr(x_clr), .inc(sec_carry), .load(load), .load_val(set_min),
    .count(min_count), .carry(min_carry)
  );

  rtc_mod_counter #(.W(HOUR_W), .MAX(HOUR_MAX - 1)) u_hour (
    .clk(clk), .x_clr(x_clr), .inc(min_carry), .load(load), .load_val(set_hour),
    .count(hour_count), .carry(hour_carry)
  );

  rtc_mod_counter #(.W(DAY_W), .MAX((1 << DAY_W) - 1)) u_day (
    .clk(clk), .x_clr(x_clr), .inc(hour_carry), .load(load), .load_val(set_day),
    .count(day_count), .carry(day_carry)
  );

  // Pulses register on the same edge the counters update, so counts already
  // show the new value while a pulse is high.
  always_ff @(posedge clk) begin
    if (!x_clr) begin
      tick_sub <= 1'b0;
      tick_1s  <= 1'b0;
      tick_1m  <= 1'b0;
      tick_1h  <= 1'b0;
      tick_1d  <= 1'b0;
      day_wrap <= 1'b0;
    end else begin
      tick_sub <= sub_carry;
      tick_1s  <= div_carry;
      tick_1m  <= sec_carry;
      tick_1h  <= min_carry;
      tick_1d  <= hour_carry;
      day_wrap <= day_carry;
    end
  end

`ifdef RTC_ALARM_EN
  logic [SEC_W-1:0]  alm_sec;
  logic [MIN_W-1:0]  alm_min;
  logic [HOUR_W-1:0] alm_hour;

  always_ff @(posedge clk) begin
    if (!x_clr) begin
      alm_sec  <= '0;
      alm_min  <= '0;
      alm_hour <= '0;
    end else if (alarm_set) begin
      alm_sec  <= alarm_sec;
      alm_min  <= alarm_min;
      alm_hour <= alarm_hour;
    end
  end

  // tick_1s is never raised by a set-load, so a load cannot fire the alarm.
  assign alarm_hit = tick_1s & alarm_en & (sec_count == alm_sec) &
                     (min_count == alm_min) & (hour_count == alm_hour);
`endif

endmodule
